multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback over a shared single-port memory, and drives PC/IR write enables, ALU operand selects, register-file writeback selects and the memory request handshake. It decodes only `opcode`/`funct3` from the latched IR. `imm_gen` decodes the immediate from the same IR independently.

## Interface
Parameters: none. Encodings live in the shared package.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `opcode` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `branch_taken` in 1: ALU compare result, valid in EXEC.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request.
- `mem_we` out 1: request is a store.
- `mem_is_fetch` out 1: address mux selects PC (1) or ALU result (0).
- `ir_we` out 1: latch fetched word into IR.
- `pc_we` out 1: update PC.
- `pc_src` out 2: 0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1.
- `alu_src_a` out 1: 0 = rs1, 1 = PC.
- `alu_src_b` out 1: 0 = rs2, 1 = imm.
- `alu_op` out 2: 0 = add, 1 = branch compare, 2 = funct-decoded.
- `reg_we` out 1: register-file write.
- `wb_sel` out 2: 0 = ALU, 1 = memory data, 2 = PC+4, 3 = imm.
- `halted` out 1: core stopped in TRAP.
- `state` out 3: current state, for debug.

## Operation
- State encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7. Outputs are Moore/Mealy-combinational from the state register plus inputs.
- In any state not listed below, every output is 0.
- **FETCH**
  - Outputs: `mem_req` = 1, `mem_is_fetch` = 1.
  - On `mem_ready`: `ir_we` = 1 in the same cycle, then go to DECODE.
  - Otherwise hold in FETCH.
- **DECODE**
  - One cycle, no side effects.
  - Illegal encoding goes to TRAP; otherwise go to EXEC.
- **Illegal encodings**
  - Any opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM}.
  - LOAD with `funct3` ∈ {3, 6, 7}.
  - STORE with `funct3` > 2.
  - BRANCH with `funct3` ∈ {2, 3}.
  - JALR with `funct3` ≠ 0.
- **EXEC**
  - OP: `alu_op` = 2, `alu_src_b` = 0; go to WB.
  - OP-IMM: `alu_op` = 2, `alu_src_b` = 1; go to WB.
  - AUIPC: `alu_src_a` = 1, `alu_src_b` = 1, `alu_op` = 0; go to WB.
  - LUI, JAL, JALR: go to WB.
  - LOAD/STORE: `alu_op` = 0, `alu_src_b` = 1 to compute the address; go to MEM.
  - BRANCH: `alu_op` = 1, `pc_we` = 1, `pc_src` = `branch_taken` ? 1 : 0; go to FETCH.
  - MISC-MEM (FENCE) is a NOP: `pc_we` = 1, `pc_src` = 0; go to FETCH.
  - SYSTEM (ECALL/EBREAK) goes to TRAP.
- **MEM**
  - Outputs: `mem_req` = 1, `mem_we` = (STORE), `mem_is_fetch` = 0. Hold until `mem_ready`.
  - LOAD on `mem_ready`: go to WB.
  - STORE on `mem_ready`: `pc_we` = 1, `pc_src` = 0; go to FETCH.
- **WB**
  - Outputs: `reg_we` = 1, `pc_we` = 1; go to FETCH.
  - `wb_sel`: LUI = 3, JAL/JALR = 2, LOAD = 1, otherwise 0.
  - `pc_src`: JAL = 1, JALR = 2, otherwise 0.
- **TRAP**
  - `halted` = 1; all other outputs 0. Exit only by `rst`.

## Timing
- **Reset:** while `rst` is high at a clock edge, the state becomes FETCH. While `rst` is asserted, all outputs are forced to 0, including `mem_req`. The first fetch request is issued the cycle after `rst` falls.
- **Reset mid-transaction:** reset during FETCH/MEM with a request outstanding abandons the request. The memory must drop it, and no PC/IR/reg write occurs that cycle.
- **Memory handshake:**
  - Once raised, `mem_req`, `mem_we` and `mem_is_fetch` stay stable until a cycle with `mem_ready` = 1.
  - `mem_ready` while `mem_req` = 0 is ignored.
  - A zero-wait memory returns `mem_ready` in the first request cycle.
- **Latency with zero-wait memory:**
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH/FENCE: 3 cycles.
  - Each memory wait cycle adds 1.
- **Write-enable pulses:** `pc_we`, `reg_we` and `ir_we` are exactly one cycle wide per instruction.
- **Write ordering:** `reg_we` and `pc_we` coincide in WB, so writeback must use the pre-update PC+4.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode localparams (7-bit);
  - the state encoding;
  - the `pc_src`, `wb_sel` and `alu_op` encodings.
- Package constants are shared with the datapath muxes and `imm_gen`.
- One combinational sub-module, `ctrl_decode`, maps `opcode`/`funct3` to an instruction class and an illegal flag. The FSM in `multicycle_ctrl` consumes only that class.

## Test plan
- **Reset:** hold `rst` 3 cycles with `mem_ready` = 1 → all outputs 0 and `state` = 0. Release → `mem_req` = 1 and `mem_is_fetch` = 1 on the next cycle.
- **ADDI, zero-wait:** opcode 0010011 → `ir_we` at cycle 1, then DECODE, then EXEC (`alu_src_b` = 1, `alu_op` = 2), then WB (`reg_we` = 1, `wb_sel` = 0, `pc_we` = 1, `pc_src` = 0). Back to FETCH after 4 cycles.
- **SW with 3 wait cycles in MEM:** `mem_req`/`mem_we` = 1 steady for 4 cycles. `pc_we` pulses once on the `mem_ready` cycle, and `reg_we` never asserts.
- **BEQ:** with `branch_taken` = 1 → `pc_src` = 1 in EXEC; with 0 → `pc_src` = 0. Both take 3 cycles and `reg_we` stays 0.
- **JAL and LW writeback:** JAL → `wb_sel` = 2, `pc_src` = 1. LW → MEM then WB with `wb_sel` = 1.
- **Illegal encodings and traps:** opcode 1111111, LOAD with `funct3` = 7, and ECALL each → TRAP. Then `halted` = 1 and no further `mem_req` despite `mem_ready` toggling; `rst` recovers to FETCH.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared encodings for the RV32I multi-cycle core: 7-bit opcodes, the
//   control FSM state encoding, the instruction classes produced by
//   ctrl_decode, and the select encodings used by the datapath muxes
//   (pc_src, wb_sel, alu_op). imm_gen and the datapath import the same
//   constants so the control and data sides cannot drift apart.
package riscv_pkg;

  // Major opcodes, IR[6:0]
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Control FSM states; 5 and 6 are unused encodings.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  // Instruction classes seen by the FSM.
  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OP_IMM  = 4'd7,
    CLS_OP      = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd15
  } instr_class_e;

  // Next-PC select
  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;  // PC + 4
  localparam logic [1:0] PC_SRC_PC_IMM = 2'd1;  // PC + imm
  localparam logic [1:0] PC_SRC_JALR   = 2'd2;  // (rs1 + imm) & ~1

  // Register-file writeback select
  localparam logic [1:0] WB_SEL_ALU    = 2'd0;
  localparam logic [1:0] WB_SEL_MEM    = 2'd1;
  localparam logic [1:0] WB_SEL_PC4    = 2'd2;
  localparam logic [1:0] WB_SEL_IMM    = 2'd3;

  // ALU operation class
  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_CMP    = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'd2;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
//   Purely combinational classifier: maps IR opcode/funct3 to an
//   instruction class and flags encodings the core does not implement.
// Ports:
//   opcode    in  [6:0]  IR[6:0]
//   funct3    in  [2:0]  IR[14:12]
//   cls       out [3:0]  instr_class_e value
//   illegal   out        encoding is not supported (cls == CLS_ILLEGAL)
module ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [3:0] cls,
  output logic       illegal
);

  instr_class_e cls_w;

  always_comb begin
    cls_w = CLS_ILLEGAL;
    case (opcode)
      OPC_LUI:      cls_w = CLS_LUI;
      OPC_AUIPC:    cls_w = CLS_AUIPC;
      OPC_JAL:      cls_w = CLS_JAL;
      OPC_JALR:     cls_w = (funct3 == 3'd0) ? CLS_JALR : CLS_ILLEGAL;
      // BEQ/BNE/BLT/BGE/BLTU/BGEU; funct3 2 and 3 are reserved
      OPC_BRANCH:   cls_w = (funct3 == 3'd2 || funct3 == 3'd3) ? CLS_ILLEGAL : CLS_BRANCH;
      // LB/LH/LW/LBU/LHU; 3, 6, 7 are reserved (no RV64 loads)
      OPC_LOAD:     cls_w = (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)
                            ? CLS_ILLEGAL : CLS_LOAD;
      // SB/SH/SW only
      OPC_STORE:    cls_w = (funct3 > 3'd2) ? CLS_ILLEGAL : CLS_STORE;
      OPC_OP_IMM:   cls_w = CLS_OP_IMM;
      OPC_OP:       cls_w = CLS_OP;
      OPC_MISC_MEM: cls_w = CLS_FENCE;
      OPC_SYSTEM:   cls_w = CLS_SYSTEM;
      default:      cls_w = CLS_ILLEGAL;
    endcase
  end

  assign cls     = cls_w;
  assign illegal = (cls_w == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle control FSM for the RV32I core. Sequences
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB] over a single-port memory and
//   drives the datapath enables/selects. Halts in TRAP on illegal encodings
//   and ECALL/EBREAK; only rst leaves TRAP.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode, funct3      fields of the latched IR
//   branch_taken        ALU compare result, used in EXEC
//   mem_ready           memory completes the current request this cycle
//   mem_req/mem_we      memory request / request is a store
//   mem_is_fetch        address mux: 1 = PC, 0 = ALU result
//   ir_we, pc_we        IR / PC write enables (one-cycle pulses)
//   pc_src              next-PC select (riscv_pkg PC_SRC_*)
//   alu_src_a/b         ALU operand selects (a: 0 rs1/1 PC, b: 0 rs2/1 imm)
//   alu_op              ALU operation class (riscv_pkg ALU_OP_*)
//   reg_we, wb_sel      register-file write enable and source select
//   halted              core stopped in TRAP
//   state               current FSM state, for debug
//
// Memory handshake: mem_req is raised by the FSM and, together with mem_we
// and mem_is_fetch, held constant until the first cycle in which mem_ready
// is 1; that cycle completes the transfer (ready may already be 1 in the
// first request cycle). mem_ready is ignored whenever mem_req is 0. A reset
// abandons any outstanding request: all outputs drop to 0 that cycle.
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_fetch,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       halted,
  output logic [2:0] state
);

  state_e       state_q, state_d;
  instr_class_e cls_q, cls_d;

  logic [3:0]   dec_cls;
  logic         dec_illegal;

  ctrl_decode u_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_ILLEGAL;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SRC_PLUS4;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_OP_ADD;
    reg_we       = 1'b0;
    wb_sel       = WB_SEL_ALU;
    halted       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // Capture the class once; the IR is stable for the rest of the
        // instruction, so later states work from cls_q alone.
        cls_d   = instr_class_e'(dec_cls);
        state_d = dec_illegal ? ST_TRAP : ST_EXEC;
      end

      ST_EXEC: begin
        case (cls_q)
          CLS_OP: begin
            alu_op  = ALU_OP_FUNCT;
            state_d = ST_WB;
          end
          CLS_OP_IMM: begin
            alu_op    = ALU_OP_FUNCT;
            alu_src_b = 1'b1;
            state_d   = ST_WB;
          end
          CLS_AUIPC: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
            state_d   = ST_WB;
          end
          CLS_LUI, CLS_JAL, CLS_JALR: begin
            state_d = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_b = 1'b1;  // rs1 + imm = effective address
            state_d   = ST_MEM;
          end
          CLS_BRANCH: begin
            alu_op  = ALU_OP_CMP;
            pc_we   = 1'b1;
            pc_src  = branch_taken ? PC_SRC_PC_IMM : PC_SRC_PLUS4;
            state_d = ST_FETCH;
          end
          CLS_FENCE: begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end
          default: begin
            // ECALL/EBREAK (and anything unexpected) stop the core.
            state_d = ST_TRAP;
          end
        endcase
      end

      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == CLS_STORE);
        if (mem_ready) begin
          if (cls_q == CLS_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_FETCH;
        case (cls_q)
          CLS_LUI:  wb_sel = WB_SEL_IMM;
          CLS_JAL: begin
            wb_sel = WB_SEL_PC4;
            pc_src = PC_SRC_PC_IMM;
          end
          CLS_JALR: begin
            wb_sel = WB_SEL_PC4;
            pc_src = PC_SRC_JALR;
          end
          CLS_LOAD: wb_sel = WB_SEL_MEM;
          default:  wb_sel = WB_SEL_ALU;
        endcase
      end

      ST_TRAP: begin
        halted = 1'b1;
      end

      default: begin
        // Unused encodings: outputs stay 0 and the core halts.
        state_d = ST_TRAP;
      end
    endcase

    // Reset overrides everything so an in-flight request is dropped and no
    // architectural write happens in the reset cycle.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_is_fetch = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = PC_SRC_PLUS4;
      alu_src_a    = 1'b0;
      alu_src_b    = 1'b0;
      alu_op       = ALU_OP_ADD;
      reg_we       = 1'b0;
      wb_sel       = WB_SEL_ALU;
      halted       = 1'b0;
    end
  end

  assign state = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Per-cycle vector bench for multicycle_ctrl. Each row gives the inputs for
//   one clock cycle and the full expected output word for that cycle.
module tb_multicycle_ctrl;

  // Local opcode constants (kept independent of the design package)
  localparam logic [6:0] O_LUI    = 7'b0110111;
  localparam logic [6:0] O_AUIPC  = 7'b0010111;
  localparam logic [6:0] O_JAL    = 7'b1101111;
  localparam logic [6:0] O_JALR   = 7'b1100111;
  localparam logic [6:0] O_BRANCH = 7'b1100011;
  localparam logic [6:0] O_LOAD   = 7'b0000011;
  localparam logic [6:0] O_STORE  = 7'b0100011;
  localparam logic [6:0] O_OPIMM  = 7'b0010011;
  localparam logic [6:0] O_OP     = 7'b0110011;
  localparam logic [6:0] O_FENCE  = 7'b0001111;
  localparam logic [6:0] O_SYSTEM = 7'b1110011;
  localparam logic [6:0] O_BAD    = 7'b1111111;

  localparam int W = 18;

  typedef struct {
    string      name;
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       bt;
    logic       mr;
    logic       rnd_mr;   // mem_ready randomized (row has no request)
    logic [W-1:0] exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req, mem_we, mem_is_fetch, ir_we, pc_we;
  logic [1:0] pc_src;
  logic       alu_src_a, alu_src_b;
  logic [1:0] alu_op;
  logic       reg_we;
  logic [1:0] wb_sel;
  logic       halted;
  logic [2:0] state;

  multicycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_is_fetch (mem_is_fetch),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .halted       (halted),
    .state        (state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  vec_t         vecs[$];

  function automatic logic [W-1:0] pk(
    input logic req, input logic we, input logic fet, input logic ir,
    input logic pcwe, input logic [1:0] pcs, input logic a, input logic b,
    input logic [1:0] aop, input logic rwe, input logic [1:0] wbs,
    input logic hlt, input logic [2:0] st);
    return {req, we, fet, ir, pcwe, pcs, a, b, aop, rwe, wbs, hlt, st};
  endfunction

  function automatic logic [W-1:0] idle(input logic [2:0] st);
    return pk(0,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,0,st);
  endfunction

  function automatic logic [W-1:0] observed();
    return {mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_src, alu_src_a,
            alu_src_b, alu_op, reg_we, wb_sel, halted, state};
  endfunction

  // Expected output words used repeatedly
  logic [W-1:0] f_wait, f_done, trap_o;

  // ---------------- driver ----------------
  task automatic step(input string nm, input logic r, input logic [6:0] op,
                      input logic [2:0] f3, input logic bt, input logic mr,
                      input logic rnd, input logic [W-1:0] e);
    logic [W-1:0] got, want;
    string        wname;
    @(posedge clk);
    #1;
    rst          = r;
    opcode       = op;
    funct3       = f3;
    branch_taken = bt;
    mem_ready    = rnd ? 1'($urandom_range(0, 1)) : mr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    got   = observed();
    want  = exp_q.pop_front();
    wname = name_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b (req we fet ir pcwe pcsrc a b aluop rwe wbsel hlt state)",
               wname, got, want);
    end
  endtask

  task automatic add(input string nm, input logic r, input logic [6:0] op,
                     input logic [2:0] f3, input logic bt, input logic mr,
                     input logic rnd, input logic [W-1:0] e);
    vec_t v;
    v.name = nm; v.rst = r; v.op = op; v.f3 = f3; v.bt = bt;
    v.mr = mr; v.rnd_mr = rnd; v.exp = e;
    vecs.push_back(v);
  endtask

  // Fetch, decode, optional exec, then halted with mem_ready toggling; reset recovers.
  task automatic trap_seq(input string nm, input logic [6:0] op,
                          input logic [2:0] f3, input logic via_exec);
    step({nm, "_f"}, 0, op, f3, 0, 1, 0, f_done);
    step({nm, "_d"}, 0, op, f3, 0, 0, 1, idle(3'd1));
    if (via_exec) step({nm, "_e"}, 0, op, f3, 0, 0, 1, idle(3'd2));
    for (int i = 0; i < 5; i++)
      step({nm, "_halt"}, 0, op, f3, 1'($urandom_range(0, 1)), 0, 1, trap_o);
    step({nm, "_rst"}, 1, op, f3, 0, 1, 0, idle(3'd0));
    step({nm, "_refetch"}, 0, op, f3, 0, 0, 0, f_wait);
  endtask

  // ---------------- test ----------------
  initial begin
    f_wait = pk(1,0,1,0,0,2'd0,0,0,2'd0,0,2'd0,0,3'd0);
    f_done = pk(1,0,1,1,0,2'd0,0,0,2'd0,0,2'd0,0,3'd0);
    trap_o = pk(0,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,1,3'd7);

    // Reset held 3 cycles with mem_ready high, then release
    for (int i = 0; i < 3; i++) add("reset", 1, O_OPIMM, 0, 0, 1, 0, idle(3'd0));
    add("release_fetch", 0, O_OPIMM, 0, 0, 0, 0, f_wait);

    // ADDI zero-wait
    add("addi_f", 0, O_OPIMM, 0, 0, 1, 0, f_done);
    add("addi_d", 0, O_OPIMM, 0, 0, 0, 1, idle(3'd1));
    add("addi_e", 0, O_OPIMM, 0, 0, 0, 1, pk(0,0,0,0,0,2'd0,0,1,2'd2,0,2'd0,0,3'd2));
    add("addi_w", 0, O_OPIMM, 0, 0, 0, 1, pk(0,0,0,0,1,2'd0,0,0,2'd0,1,2'd0,0,3'd4));

    // ADD (register-register)
    add("add_f", 0, O_OP, 0, 0, 1, 0, f_done);
    add("add_d", 0, O_OP, 0, 0, 0, 1, idle(3'd1));
    add("add_e", 0, O_OP, 0, 0, 0, 1, pk(0,0,0,0,0,2'd0,0,0,2'd2,0,2'd0,0,3'd2));
    add("add_w", 0, O_OP, 0, 0, 0, 1, pk(0,0,0,0,1,2'd0,0,0,2'd0,1,2'd0,0,3'd4));

    // SW with 3 wait cycles in MEM
    add("sw_f", 0, O_STORE, 2, 0, 1, 0, f_done);
    add("sw_d", 0, O_STORE, 2, 0, 0, 1, idle(3'd1));
    add("sw_e", 0, O_STORE, 2, 0, 0, 1, pk(0,0,0,0,0,2'd0,0,1,2'd0,0,2'd0,0,3'd2));
    for (int i = 0; i < 3; i++)
      add("sw_mwait", 0, O_STORE, 2, 0, 0, 0, pk(1,1,0,0,0,2'd0,0,0,2'd0,0,2'd0,0,3'd3));
    add("sw_mdone", 0, O_STORE, 2, 0, 1, 0, pk(1,1,0,0,1,2'd0,0,0,2'd0,0,2'd0,0,3'd3));

    // BEQ taken / not taken
    add("beq_t_f", 0, O_BRANCH, 0, 0, 1, 0, f_done);
    add("beq_t_d", 0, O_BRANCH, 0, 0, 0, 1, idle(3'd1));
    add("beq_t_e", 0, O_BRANCH, 0, 1, 0, 1, pk(0,0,0,0,1,2'd1,0,0,2'd1,0,2'd0,0,3'd2));
    add("beq_n_f", 0, O_BRANCH, 0, 1, 1, 0, f_done);
    add("beq_n_d", 0, O_BRANCH, 0, 1, 0, 1, idle(3'd1));
    add("beq_n_e", 0, O_BRANCH, 0, 0, 0, 1, pk(0,0,0,0,1,2'd0,0,0,2'd1,0,2'd0,0,3'd2));

    // JAL / JALR
    add("jal_f", 0, O_JAL, 0, 0, 1, 0, f_done);
    add("jal_d", 0, O_JAL, 0, 0, 0, 1, idle(3'd1));
    add("jal_e", 0, O_JAL, 0, 0, 0, 1, idle(3'd2));
    add("jal_w", 0, O_JAL, 0, 0, 0, 1, pk(0,0,0,0,1,2'd1,0,0,2'd0,1,2'd2,0,3'd4));
    add("jalr_f", 0, O_JALR, 0, 0, 1, 0, f_done);
    add("jalr_d", 0, O_JALR, 0, 0, 0, 1, idle(3'd1));
    add("jalr_e", 0, O_JALR, 0, 0, 0, 1, idle(3'd2));
    add("jalr_w", 0, O_JALR, 0, 0, 0, 1, pk(0,0,0,0,1,2'd2,0,0,2'd0,1,2'd2,0,3'd4));

    // LW with one wait in FETCH and one in MEM
    add("lw_fwait", 0, O_LOAD, 2, 0, 0, 0, f_wait);
    add("lw_f", 0, O_LOAD, 2, 0, 1, 0, f_done);
    add("lw_d", 0, O_LOAD, 2, 0, 0, 1, idle(3'd1));
    add("lw_e", 0, O_LOAD, 2, 0, 0, 1, pk(0,0,0,0,0,2'd0,0,1,2'd0,0,2'd0,0,3'd2));
    add("lw_mwait", 0, O_LOAD, 2, 0, 0, 0, pk(1,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,0,3'd3));
    add("lw_mdone", 0, O_LOAD, 2, 0, 1, 0, pk(1,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,0,3'd3));
    add("lw_w", 0, O_LOAD, 2, 0, 0, 1, pk(0,0,0,0,1,2'd0,0,0,2'd0,1,2'd1,0,3'd4));

    // LUI, AUIPC, FENCE
    add("lui_f", 0, O_LUI, 0, 0, 1, 0, f_done);
    add("lui_d", 0, O_LUI, 0, 0, 0, 1, idle(3'd1));
    add("lui_e", 0, O_LUI, 0, 0, 0, 1, idle(3'd2));
    add("lui_w", 0, O_LUI, 0, 0, 0, 1, pk(0,0,0,0,1,2'd0,0,0,2'd0,1,2'd3,0,3'd4));
    add("auipc_f", 0, O_AUIPC, 0, 0, 1, 0, f_done);
    add("auipc_d", 0, O_AUIPC, 0, 0, 0, 1, idle(3'd1));
    add("auipc_e", 0, O_AUIPC, 0, 0, 0, 1, pk(0,0,0,0,0,2'd0,1,1,2'd0,0,2'd0,0,3'd2));
    add("auipc_w", 0, O_AUIPC, 0, 0, 0, 1, pk(0,0,0,0,1,2'd0,0,0,2'd0,1,2'd0,0,3'd4));
    add("fence_f", 0, O_FENCE, 0, 0, 1, 0, f_done);
    add("fence_d", 0, O_FENCE, 0, 0, 0, 1, idle(3'd1));
    add("fence_e", 0, O_FENCE, 0, 0, 0, 1, pk(0,0,0,0,1,2'd0,0,0,2'd0,0,2'd0,0,3'd2));

    // Reset while a store request is outstanding in MEM
    add("rstmem_f", 0, O_STORE, 0, 0, 1, 0, f_done);
    add("rstmem_d", 0, O_STORE, 0, 0, 0, 1, idle(3'd1));
    add("rstmem_e", 0, O_STORE, 0, 0, 0, 1, pk(0,0,0,0,0,2'd0,0,1,2'd0,0,2'd0,0,3'd2));
    add("rstmem_m", 0, O_STORE, 0, 0, 0, 0, pk(1,1,0,0,0,2'd0,0,0,2'd0,0,2'd0,0,3'd3));
    add("rstmem_rst", 1, O_STORE, 0, 0, 1, 0, idle(3'd0));
    add("rstmem_refetch", 0, O_STORE, 0, 0, 0, 0, f_wait);

    // Apply the table
    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].name, vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].bt,
           vecs[i].mr, vecs[i].rnd_mr, vecs[i].exp);

    // Trap corner cases: illegal opcode, LOAD funct3=7, ECALL
    trap_seq("trap_badop", O_BAD, 3'd0, 1'b0);
    trap_seq("trap_ld7", O_LOAD, 3'd7, 1'b0);
    trap_seq("trap_ecall", O_SYSTEM, 3'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
